pitch_frac_search: RTL
======================

// Module: pitch_frac_search
// PURPOSE
//  Fractional-lag refinement stage of the G.729 closed-loop pitch search (Pitch_fr3 step).
//  Given the integer lag t0 and the correlation vector in scratch memory, sequences the
//  Interpol_3 block over frac = -2..+2. Keeps the largest interpolated correlation.
//  Emits the final (t0, frac) pair with frac in {-1,0,1}. Sits directly upstream of, and
//  controls, Interpol_3 through its start/done handshake.
// PARAMETERS
//  ADDR_W   12  scratch address width (matches Interpol_3 x port)
//  DATA_W   16  sample / correlation / lag width
//  FRAC_MIN -2  first fraction evaluated (signed)
//  FRAC_MAX  2  last fraction evaluated (signed)
//  T0_SKIP  84  lag threshold for the skip rule (PITCH_FRAC_SKIP_EN only)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high
//  start          in   1       1-cycle pulse; samples t0, i_subfr, corr_base
//  t0             in   16      integer pitch lag (unsigned, 20..143)
//  i_subfr        in   1       0 = first subframe, 1 = second
//  corr_base      in   ADDR_W  scratch address of corr[0]
//  interp_start   out  1       1-cycle start pulse to Interpol_3
//  interp_x       out  ADDR_W  corr_base + t0 (mod 2^ADDR_W); stable while busy
//  interp_frac    out  16      current fraction, two's complement
//  interp_result  in   16      Interpol_3 returnS, signed
//  interp_done    in   1       Interpol_3 done pulse
//  t0_out         out  16      adjusted integer lag
//  frac_out       out  16      final fraction, signed, in {-1,0,1}
//  max_out        out  16      winning interpolated correlation, signed
//  done           out  1       1-cycle completion pulse
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; internal T0/FRAC/MAX/BEST registers 0.
//  - Reset asserted mid-search: back to IDLE next edge. No further interp_start is issued.
//    A late interp_done is ignored.
//  - FSM states: IDLE, CHECK, LAUNCH, WAIT, COMPARE, ADJUST, DONE.
//  - IDLE: on start, latch inputs and go to CHECK. Start is ignored in every other state.
//  - CHECK: set frac = FRAC_MIN, go to LAUNCH.
//  - LAUNCH: assert interp_start for exactly 1 cycle, go to WAIT.
//  - interp_x and interp_frac are driven from registers. They are held stable from LAUNCH
//    until the matching interp_done, because Interpol_3 samples them one cycle after start.
//  - WAIT: hold until interp_done=1, then capture interp_result and go to COMPARE.
//    There is no timeout.
//  - COMPARE:
//    - If frac == FRAC_MIN, MAX is loaded unconditionally.
//    - Otherwise MAX is updated only if result > MAX, using a signed 16-bit strict compare.
//      On ties the earlier (more negative) frac wins.
//    - BEST records the winning frac.
//    - If frac < FRAC_MAX: frac = frac+1, go to LAUNCH. Else go to ADJUST.
//  - ADJUST:
//    - BEST == -2 -> frac_out = 1,  t0_out = t0-1.
//    - BEST == +2 -> frac_out = -1, t0_out = t0+1.
//    - Otherwise  -> frac_out = BEST, t0_out = t0.
//    - Lag arithmetic is 16-bit wrapping; no saturation (valid lag range cannot wrap).
//  - DONE: done=1 for 1 cycle, go to IDLE.
//  - t0_out, frac_out and max_out are updated at the ADJUST edge. They hold until the next
//    ADJUST or reset.
//  - Latency: start -> done = 3 + sum over 5 calls of (1 + Interpol_3 latency + 1) cycles.
//  - interp_done outside WAIT is ignored. interp_start never coincides with done.
// CONFIGURATION
//  - PITCH_FRAC_SKIP_EN defined: in CHECK, if i_subfr==0 and t0 > T0_SKIP, no Interpol_3
//    call is made. The block goes straight to ADJUST with BEST=0 and MAX=0, giving
//    t0_out = t0, frac_out = 0, done 3 cycles after start.
//  - PITCH_FRAC_SKIP_EN undefined: all five fractions are always evaluated; i_subfr is
//    unused.
// TESTING
//  1. Results -2..2 = {10,30,50,20,5}, t0=60 -> 5 interp_start pulses, frac sequence
//     FFFE,FFFF,0,1,2; done; t0_out=60, frac_out=0, max_out=50.
//  2. Results {90,30,50,20,5}, t0=60 -> t0_out=59, frac_out=1, max_out=90.
//  3. Results {-5,-3,-3,-8,-1}, t0=40 -> t0_out=41, frac_out=FFFF, max_out=FFFF (-1).
//     Also repeat with {7,7,7,7,7} -> tie keeps -2 -> t0_out=39, frac_out=1.
//  4. SKIP_EN defined, i_subfr=0, t0=100 -> no interp_start, done 3 cycles after start,
//     t0_out=100, frac_out=0. Same with i_subfr=1 -> full 5-call search.
//  5. Reset asserted during 3rd WAIT, late interp_done pulse -> IDLE, outputs 0, no done.
//     A start pulse during WAIT is ignored.
//  6. corr_base=FF0, t0=20 -> interp_x=004 (wrap), held constant across all 5 calls.

Source files
------------

// File: rtl/pitch_frac_search.sv
// rtl/pitch_frac_search.sv - G.729 fractional pitch lag refinement sequencer driving Interpol_3
// Optional: PITCH_FRAC_SKIP_EN skips the search for long first-subframe lags.
module pitch_frac_search #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int FRAC_MIN = -2,
    parameter int FRAC_MAX = 2,
    parameter int T0_SKIP  = 84
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] t0,
    input  logic              i_subfr,
    input  logic [ADDR_W-1:0] corr_base,
    output logic              interp_start,
    output logic [ADDR_W-1:0] interp_x,
    output logic [DATA_W-1:0] interp_frac,
    input  logic [DATA_W-1:0] interp_result,
    input  logic              interp_done,
    output logic [DATA_W-1:0] t0_out,
    output logic [DATA_W-1:0] frac_out,
    output logic [DATA_W-1:0] max_out,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_COMPARE,
        S_ADJUST,
        S_DONE
    } state_t;

    localparam logic [DATA_W-1:0] L_FRAC_MIN = DATA_W'(FRAC_MIN);
    localparam logic [DATA_W-1:0] L_FRAC_MAX = DATA_W'(FRAC_MAX);
    localparam logic [DATA_W-1:0] L_EDGE_LO  = DATA_W'(-2);
    localparam logic [DATA_W-1:0] L_EDGE_HI  = DATA_W'(2);
    localparam logic [DATA_W-1:0] L_ONE      = DATA_W'(1);
    localparam logic [DATA_W-1:0] L_NEG_ONE  = DATA_W'(-1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_t0;
    logic [ADDR_W-1:0] r_x;
    logic [DATA_W-1:0] r_frac;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_best;
    logic [DATA_W-1:0] r_t0_out;
    logic [DATA_W-1:0] r_frac_out;
    logic [DATA_W-1:0] r_max_out;
    logic              w_skip;
    logic              w_better;
    logic              w_last;

`ifdef PITCH_FRAC_SKIP_EN
    logic r_subfr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_subfr <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_subfr <= i_subfr;
        end
    end

    assign w_skip = !r_subfr && (r_t0 > DATA_W'(T0_SKIP));
`else
    logic [DATA_W-1:0] w_unused_skip;

    assign w_unused_skip = {{(DATA_W-1){1'b0}}, i_subfr} ^ DATA_W'(T0_SKIP);
    assign w_skip        = 1'b0;
`endif

    // First fraction always seeds MAX; later ones need a strictly larger signed value,
    // so ties keep the more negative fraction.
    assign w_better = (r_frac == L_FRAC_MIN) || ($signed(r_res) > $signed(r_max));
    assign w_last   = $signed(r_frac) >= $signed(L_FRAC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        interp_start = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE:    if (start) w_next = S_CHECK;
            S_CHECK:   w_next = w_skip ? S_ADJUST : S_LAUNCH;
            S_LAUNCH: begin
                interp_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT:    if (interp_done) w_next = S_COMPARE;
            S_COMPARE: w_next = w_last ? S_ADJUST : S_LAUNCH;
            S_ADJUST:  w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_t0       <= '0;
            r_x        <= '0;
            r_frac     <= '0;
            r_res      <= '0;
            r_max      <= '0;
            r_best     <= '0;
            r_t0_out   <= '0;
            r_frac_out <= '0;
            r_max_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_t0 <= t0;
                        r_x  <= corr_base + t0[ADDR_W-1:0];
                    end
                end
                S_CHECK: begin
                    if (w_skip) begin
                        r_best <= '0;
                        r_max  <= '0;
                    end else begin
                        r_frac <= L_FRAC_MIN;
                    end
                end
                S_WAIT: begin
                    if (interp_done) begin
                        r_res <= interp_result;
                    end
                end
                S_COMPARE: begin
                    if (w_better) begin
                        r_max  <= r_res;
                        r_best <= r_frac;
                    end
                    if (!w_last) begin
                        r_frac <= r_frac + L_ONE;
                    end
                end
                S_ADJUST: begin
                    // Edge winners fold onto the neighbouring integer lag.
                    if (r_best == L_EDGE_LO) begin
                        r_frac_out <= L_ONE;
                        r_t0_out   <= r_t0 - L_ONE;
                    end else if (r_best == L_EDGE_HI) begin
                        r_frac_out <= L_NEG_ONE;
                        r_t0_out   <= r_t0 + L_ONE;
                    end else begin
                        r_frac_out <= r_best;
                        r_t0_out   <= r_t0;
                    end
                    r_max_out <= r_max;
                end
                default: begin
                end
            endcase
        end
    end

    assign interp_x    = r_x;
    assign interp_frac = r_frac;
    assign t0_out      = r_t0_out;
    assign frac_out    = r_frac_out;
    assign max_out     = r_max_out;

endmodule
